// File: rtl/dip_switch_ctrl_pkg.sv
// ============================================================================
// Module  : dip_pkg
// Brief   : Shared word offsets, control bit indices and FSM encoding for
//           the DIP switch controller.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package dip_pkg;

  localparam logic [1:0] WORD_LO     = 2'd0;
  localparam logic [1:0] WORD_HI     = 2'd1;
  localparam logic [1:0] WORD_CTRL   = 2'd2;
  localparam logic [1:0] WORD_PERIOD = 2'd3;

  localparam int BIT_IE   = 0;
  localparam int BIT_PEND = 1;
  localparam int BIT_BUSY = 2;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_t;

endpackage

`default_nettype wire

// File: rtl/dip_switch_ctrl_sync2.sv
// ============================================================================
// Module  : sync2
// Brief   : Parameterized two-flop synchronizer, async active-low reset to ones.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module sync2 #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= '1;
      r_sync <= '1;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

`default_nettype wire

// File: rtl/dip_switch_ctrl.sv
// ============================================================================
// Module  : dip_switch_ctrl
// Brief   : Debounced, bus-readable 64-line DIP switch image with change IRQ.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module dip_switch_ctrl
  import dip_pkg::*;
#(
  parameter int               CNT_W            = 20,
  parameter logic [CNT_W-1:0] DEBOUNCE_DEFAULT = 20'd500000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  In0,
  input  logic [7:0]  In1,
  input  logic [7:0]  In2,
  input  logic [7:0]  In3,
  input  logic [7:0]  In4,
  input  logic [7:0]  In5,
  input  logic [7:0]  In6,
  input  logic [7:0]  In7,
  input  logic [1:0]  Addr,
  input  logic        WE,
  input  logic [31:0] DIn,
  output logic [31:0] DOut,
  output logic        IRQ
);

  logic [63:0]      w_sync;
  logic [63:0]      r_cand;
  logic [63:0]      r_stable;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_period;
  logic [CNT_W-1:0] w_last;
  logic             r_ie;
  logic             r_pending;
  state_t           r_state;
  logic             w_wr_ctrl;
  logic             w_wr_period;
  logic             w_busy;
  logic             w_unused_din;

  sync2 #(.WIDTH(64)) u_sync (
    .clk   (clk),
    .rst_n (reset),
    .i_d   ({In7, In6, In5, In4, In3, In2, In1, In0}),
    .o_q   (w_sync)
  );

  // A period of zero behaves as one, so the terminal count is zero in both cases.
  assign w_last       = (r_period == '0) ? '0 : r_period - CNT_W'(1);
  assign w_wr_ctrl    = WE && (Addr == WORD_CTRL);
  assign w_wr_period  = WE && (Addr == WORD_PERIOD);
  assign w_busy       = (r_state == COUNT);
  assign w_unused_din = ^DIn[31:CNT_W];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cand    <= '1;
      r_stable  <= '1;
      r_cnt     <= '0;
      r_period  <= DEBOUNCE_DEFAULT;
      r_ie      <= 1'b0;
      r_pending <= 1'b0;
      r_state   <= IDLE;
    end else begin
      if (w_wr_ctrl) begin
        r_ie <= DIn[BIT_IE];
        if (DIn[BIT_PEND]) r_pending <= 1'b0;
      end
      if (w_wr_period) r_period <= DIn[CNT_W-1:0];

      case (r_state)
        IDLE: begin
          if (w_sync != r_cand) begin
            r_cand  <= w_sync;
            r_cnt   <= '0;
            r_state <= COUNT;
          end
        end
        COUNT: begin
          if (w_sync != r_cand) begin
            r_cand <= w_sync;
            r_cnt  <= '0;
          end else if (r_cnt == w_last) begin
            r_stable <= r_cand;
            // Placed after the clear above so a same-cycle commit wins.
            if (r_cand != r_stable) r_pending <= 1'b1;
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase

      if (w_wr_period && (r_state == COUNT)) r_cnt <= '0;
    end
  end

  always_comb begin
    DOut = '0;
    case (Addr)
      WORD_LO:     DOut = ~r_stable[31:0];
      WORD_HI:     DOut = ~r_stable[63:32];
      WORD_CTRL:   DOut = {29'b0, w_busy, r_pending, r_ie};
      WORD_PERIOD: DOut = {{(32-CNT_W){1'b0}}, r_period};
      default:     DOut = '0;
    endcase
  end

  assign IRQ = r_pending & r_ie;

endmodule

`default_nettype wire

// File: tb/tb_dip_switch_ctrl.sv
// ============================================================================
// Module  : tb_dip_switch_ctrl
// Brief   : Scoreboard bench for dip_switch_ctrl using directed vectors.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_dip_switch_ctrl;

  logic        clk;
  logic        reset;
  logic [7:0]  In0, In1, In2, In3, In4, In5, In6, In7;
  logic [1:0]  Addr;
  logic        WE;
  logic [31:0] DIn;
  logic [31:0] DOut;
  logic        IRQ;

  typedef struct {
    string       name;
    logic [31:0] dout;
    logic        irq;
  } exp_t;

  exp_t q_exp[$];
  int   checks = 0;
  int   errors = 0;

  dip_switch_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .In0   (In0),
    .In1   (In1),
    .In2   (In2),
    .In3   (In3),
    .In4   (In4),
    .In5   (In5),
    .In6   (In6),
    .In7   (In7),
    .Addr  (Addr),
    .WE    (WE),
    .DIn   (DIn),
    .DOut  (DOut),
    .IRQ   (IRQ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Each queued expectation describes the cycle it was issued in.
  always @(negedge clk) begin
    if (q_exp.size() > 0) begin
      exp_t e;
      e = q_exp.pop_front();
      checks++;
      if (DOut !== e.dout) begin
        errors++;
        $display("FAIL %s dout: got %h expected %h", e.name, DOut, e.dout);
      end
      checks++;
      if (IRQ !== e.irq) begin
        errors++;
        $display("FAIL %s irq: got %b expected %b", e.name, IRQ, e.irq);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    Addr = a;
    DIn  = d;
    WE   = 1'b1;
    tick(1);
    WE   = 1'b0;
    DIn  = '0;
  endtask

  task automatic chk(input string name, input logic [1:0] a,
                     input logic [31:0] d, input logic irq);
    exp_t e;
    Addr   = a;
    e.name = name;
    e.dout = d;
    e.irq  = irq;
    q_exp.push_back(e);
    tick(1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0;
    {In7, In6, In5, In4, In3, In2, In1, In0} = '1;
    Addr = 2'd0;
    WE   = 1'b0;
    DIn  = '0;
    tick(3);
    reset = 1'b1;

    // Reset state
    chk("rst_w0", 2'd0, 32'h0, 1'b0);
    chk("rst_w1", 2'd1, 32'h0, 1'b0);
    chk("rst_w2", 2'd2, 32'h0, 1'b0);
    chk("rst_w3", 2'd3, 32'd500000, 1'b0);

    // Latency: period 4, commit visible exactly 7 edges after the change
    wr(2'd3, 32'd4);
    wr(2'd2, 32'h1);
    In0  = 8'hFE;
    Addr = 2'd0;
    tick(6);
    chk("lat_pre", 2'd0, 32'h0, 1'b0);
    chk("lat_commit", 2'd0, 32'h1, 1'b1);
    wr(2'd2, 32'h3);
    chk("lat_clear", 2'd2, 32'h1, 1'b0);

    // Release bit 0 and clear, then bounce it
    In0 = 8'hFF;
    tick(8);
    chk("release", 2'd0, 32'h0, 1'b1);
    wr(2'd2, 32'h3);
    for (int i = 0; i < 5; i++) begin
      In0[0] = i[0];
      if (i >= 2) begin
        chk("bounce_busy", 2'd2, 32'h5, 1'b0);
        tick(1);
      end else begin
        tick(2);
      end
    end
    In0[0] = 1'b1;
    tick(10);
    chk("bounce_w0", 2'd0, 32'h0, 1'b0);
    chk("bounce_w2", 2'd2, 32'h1, 1'b0);

    // High word, IE-only write keeps pending, W1C drops IRQ
    In7 = 8'h7F;
    tick(8);
    chk("hi_commit", 2'd1, 32'h8000_0000, 1'b1);
    wr(2'd2, 32'h1);
    chk("ie_only", 2'd2, 32'h3, 1'b1);
    wr(2'd2, 32'h3);
    chk("w1c", 2'd2, 32'h1, 1'b0);

    // Clear and commit in the same cycle: set wins
    In7 = 8'hFF;
    tick(6);
    wr(2'd2, 32'h3);
    chk("set_wins", 2'd2, 32'h3, 1'b1);
    chk("set_wins_w1", 2'd1, 32'h0, 1'b1);
    wr(2'd2, 32'h3);

    // Reset mid-COUNT
    In0 = 8'hFE;
    tick(4);
    chk("pre_rst_busy", 2'd2, 32'h5, 1'b0);
    reset = 1'b0;
    In0   = 8'hFF;
    tick(2);
    reset = 1'b1;
    chk("mid_rst_w0", 2'd0, 32'h0, 1'b0);
    chk("mid_rst_w1", 2'd1, 32'h0, 1'b0);
    chk("mid_rst_w2", 2'd2, 32'h0, 1'b0);
    chk("mid_rst_w3", 2'd3, 32'd500000, 1'b0);

    // Period write of 0 mid-COUNT restarts and commits one edge later
    wr(2'd2, 32'h1);
    In0 = 8'hFE;
    tick(5);
    wr(2'd3, 32'h0);
    chk("p0_busy", 2'd2, 32'h5, 1'b0);
    chk("p0_commit", 2'd0, 32'h1, 1'b1);
    chk("p0_period", 2'd3, 32'h0, 1'b1);

    tick(2);
    if (q_exp.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q_exp.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dip_switch_ctrl.md
# dip_switch_ctrl

Bus-mapped controller for the board's 64 DIP switch lines: synchronizes and debounces the raw active-low inputs, holds a stable switch image for CPU reads, and raises an interrupt request when the committed image changes. It sits on the system bridge beside the other I/O peripherals. It replaces direct combinational sampling of the switches with a sequenced, glitch-free view plus change notification.

## Interface
- `CNT_W`, 20: debounce counter and period register width.
- `DEBOUNCE_DEFAULT`, 20'd500000: period loaded at reset, in clock cycles.
- `clk` input 1: system clock; the block uses this single clock.
- `reset` input 1: asynchronous, active-low reset.
- `In0`..`In7` input 8 each: raw switch groups, active-low (switch on = 0), asynchronous to `clk`.
- `Addr` input 2: word select, bus address bits [3:2].
- `WE` input 1: write strobe for the selected word, sampled on the rising `clk` edge.
- `DIn` input 32: write data.
- `DOut` output 32: read data, combinational from `Addr` and internal registers.
- `IRQ` output 1: level interrupt request, equal to `pending & IE`.

## Operation
- Raw vector R[63:0] = {In7..In0}. Two-flop synchronizer gives S; every flop resets to all ones (all switches off).
- Registers: `cand[63:0]` (reset all ones), `stable[63:0]` (reset all ones), `cnt[CNT_W-1:0]` (reset 0), `period` (reset DEBOUNCE_DEFAULT), `IE` (reset 0), `pending` (reset 0), state (reset IDLE).
- FSM IDLE: if S != cand, then cand <= S, cnt <= 0, go to COUNT. Otherwise hold.
- FSM COUNT: if S != cand, then cand <= S and cnt <= 0, staying in COUNT (the window restarts). Else if cnt == eff_period-1, then stable <= cand; if cand != stable, pending <= 1; go to IDLE. Else cnt <= cnt+1.
- eff_period = (period == 0) ? 1 : period.
- Register map, with reads inverted so that switch on = 1:
  - word0 reads ~stable[31:0]; word1 reads ~stable[63:32]. Both are read-only, and writes to them are ignored.
  - word2 reads {29'b0, busy, pending, IE}, where busy = (state == COUNT). A write sets IE <= DIn[0]. A write with DIn[1] = 1 clears pending (write-1-to-clear).
  - word3 reads {zero-extend, period}. A write sets period <= DIn[CNT_W-1:0]. If the FSM is in COUNT, the same write also sets cnt <= 0.
- A commit that sets pending and a clear of pending in the same cycle: the set wins, so pending = 1.
- A commit with cand == stable (bounce returned to the old value) updates nothing and sets no pending.
- If switches are on at reset release, the first commit after reset sets pending. This is intended.

## Timing
- Reset asserted at any time, including mid-COUNT: all registers return to the reset values above immediately. Outputs after reset: `IRQ` = 0, word0/word1 read 0, word2 reads 0, word3 reads DEBOUNCE_DEFAULT.
- From a raw change that then stays steady, S changes 2 edges later. COUNT is entered on the next edge, and `stable` updates eff_period edges after that. Total latency from raw change to `DOut` = 3 + eff_period cycles.
- `IRQ` rises in the same cycle that `stable` updates. It falls the cycle after a clearing write, or after a write of IE = 0.
- `DOut` has zero latency: it changes in the same cycle as `Addr` or the source register.
- There is no bus wait state: every access completes in one cycle.

## Structure
- A shared package `dip_pkg` holds the word offsets (WORD_LO = 0, WORD_HI = 1, WORD_CTRL = 2, WORD_PERIOD = 3), the CTRL bit indices (IE = 0, PEND = 1, BUSY = 2), and the IDLE/COUNT state encoding.
- One sub-module, `sync2`, is a parameterized-width two-flop synchronizer with asynchronous active-low reset to ones. It is instantiated once with width 64.
- The FSM, counter, and register file live in `dip_switch_ctrl`.

## Test plan
- Reset with raw inputs all ones: word0 = 0, word2 = 0, word3 = 500000, and `IRQ` = 0.
- With period = 4 and IE = 1, drive In0 = 8'hFE and hold it: word0 = 32'h1 at exactly cycle 7 after the change, and `IRQ` = 1 in that same cycle.
- Bounce test, period 4: toggle In0 bit 0 every 2 cycles for 10 cycles, then return it to 1. Required result: busy = 1 during the bouncing, stable is never updated, and pending stays 0.
- Drive In7 = 8'h7F; after the commit, word1 = 32'h8000_0000. Then write word2 with 32'h1 (IE = 1, no clear bit): pending stays 1. Then write word2 with 32'h3: `IRQ` drops the next cycle.
- Clear and commit in the same cycle: pending stays 1 and `IRQ` stays high.
- Assert reset mid-COUNT, and separately write word3 = 0 mid-COUNT. After reset: all outputs return to their reset values. After the period write: cnt restarts and the commit occurs 1 cycle later, since period 0 behaves as 1.
